// File: rtl/bsg_lfsr_sched_pkg.sv
// Shared types and constants for the shared-LFSR scheduler.
//   state_e      : scheduler FSM encoding (visible on state_o for debug)
//   taps*_c      : Galois (right-shift) feedback masks for common widths
//   default_taps : picks one of the masks above by width, 0 if none known
package bsg_lfsr_sched_pkg;

  typedef enum logic [1:0] {
    WARMUP = 2'd0,
    SERVE  = 2'd1,
    SEED   = 2'd2
  } state_e;

  // x^8+x^6+x^5+x^4+1
  localparam logic [7:0]  taps8_c  = 8'hB8;
  // x^16+x^14+x^13+x^11+1
  localparam logic [15:0] taps16_c = 16'hB400;
  // x^32+x^22+x^2+x+1
  localparam logic [31:0] taps32_c = 32'h8020_0003;

  function automatic logic [31:0] default_taps(input int w);
    case (w)
      8:       return {24'h0, taps8_c};
      16:      return {16'h0, taps16_c};
      32:      return taps32_c;
      default: return 32'h0;
    endcase
  endfunction

endpackage

// File: rtl/bsg_lfsr_galois_step.sv
// Galois LFSR register with separate load and step enables.
//   clk, reset_n_i : clock, async active-low reset (loads seed_reset_p)
//   load_i         : load load_val_i (wins over step_i)
//   step_i         : advance one Galois step, right shift
//   load_val_i     : value to load
//   lfsr_o         : current register value
module bsg_lfsr_galois_step
  #(parameter int                   width_p      = 16,
    parameter logic [width_p-1:0]   taps_p       = 16'hB400,
    parameter logic [width_p-1:0]   seed_reset_p = 16'h0001)
  (input  logic               clk,
   input  logic               reset_n_i,
   input  logic               step_i,
   input  logic               load_i,
   input  logic [width_p-1:0] load_val_i,
   output logic [width_p-1:0] lfsr_o);

  logic [width_p-1:0] lfsr_r;
  logic [width_p-1:0] lfsr_step;

  assign lfsr_step = (lfsr_r >> 1) ^ (lfsr_r[0] ? taps_p : '0);

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i)  lfsr_r <= seed_reset_p;
    else if (load_i) lfsr_r <= load_val_i;
    else if (step_i) lfsr_r <= lfsr_step;
  end

  assign lfsr_o = lfsr_r;

endmodule

// File: rtl/bsg_lfsr_sched.sv
// One Galois LFSR shared round-robin among els_p requesters, one grant
// per cycle. After reset or a reseed the LFSR free-runs warmup_p steps
// before any value is handed out.
//   clk, reset_n_i : clock, async active-low reset
//   req_i          : per-lane request, held until granted
//   grant_o        : one-hot grant; data_o is consumed this cycle
//   data_o         : current LFSR value
//   seed_v_i/seed_i: reseed strobe and value (0 means seed_reset_p)
//   ready_o        : high while serving
//   state_o        : FSM state for debug
module bsg_lfsr_sched
  import bsg_lfsr_sched_pkg::*;
  #(parameter int                 width_p      = 16,
    parameter int                 els_p        = 4,
    parameter logic [width_p-1:0] taps_p       = width_p'(default_taps(width_p)),
    parameter logic [width_p-1:0] seed_reset_p = width_p'(1),
    parameter int                 warmup_p     = 4)
  (input  logic               clk,
   input  logic               reset_n_i,
   input  logic [els_p-1:0]   req_i,
   output logic [els_p-1:0]   grant_o,
   output logic [width_p-1:0] data_o,
   input  logic               seed_v_i,
   input  logic [width_p-1:0] seed_i,
   output logic               ready_o,
   output logic [1:0]         state_o);

  localparam int ptr_w = $clog2(els_p);
  localparam int cnt_w = (warmup_p > 1) ? $clog2(warmup_p) : 1;
  localparam logic [cnt_w-1:0] cnt_init_c = cnt_w'(warmup_p - 1);

  state_e           state_r, state_n;
  logic [cnt_w-1:0] cnt_r, cnt_n;
  logic [ptr_w-1:0] ptr_r, ptr_n;

  logic               step, load;
  logic [width_p-1:0] lfsr, load_val;
  logic [els_p-1:0]   grant;

  // A zero seed would lock the LFSR at zero forever.
  assign load_val = (seed_i == '0) ? seed_reset_p : seed_i;

  bsg_lfsr_galois_step #(
    .width_p      (width_p),
    .taps_p       (taps_p),
    .seed_reset_p (seed_reset_p)
  ) u_lfsr (
    .clk        (clk),
    .reset_n_i  (reset_n_i),
    .step_i     (step),
    .load_i     (load),
    .load_val_i (load_val),
    .lfsr_o     (lfsr)
  );

  // Rotating priority search starting at the pointer.
  logic             found;
  logic [ptr_w-1:0] winner;
  always_comb begin
    logic [ptr_w-1:0] idx;
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int k = 0; k < els_p; k++) begin
      idx = ptr_w'((int'(ptr_r) + k) % els_p);
      if (!found && req_i[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= WARMUP;
      cnt_r   <= cnt_init_c;
      ptr_r   <= '0;
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
      ptr_r   <= ptr_n;
    end
  end

  always_comb begin
    state_n = state_r;
    cnt_n   = cnt_r;
    ptr_n   = ptr_r;
    step    = 1'b0;
    load    = 1'b0;
    grant   = '0;
    if (seed_v_i) begin
      // Reseed overrides any step or grant this cycle.
      state_n = SEED;
      load    = 1'b1;
    end else begin
      case (state_r)
        SEED: begin
          state_n = WARMUP;
          cnt_n   = cnt_init_c;
        end
        WARMUP: begin
          step = 1'b1;
          if (cnt_r == '0) state_n = SERVE;
          else             cnt_n   = cnt_r - 1'b1;
        end
        SERVE: begin
          if (found) begin
            grant = els_p'(1) << winner;
            step  = 1'b1;
            ptr_n = (winner == ptr_w'(els_p - 1)) ? '0 : winner + 1'b1;
          end
        end
        default: begin
          state_n = WARMUP;
          cnt_n   = cnt_init_c;
        end
      endcase
    end
  end

  assign grant_o = grant;
  assign data_o  = lfsr;
  assign ready_o = (state_r == SERVE);
  assign state_o = state_r;

endmodule

// File: tb/tb_bsg_lfsr_sched.sv
module tb_bsg_lfsr_sched;

  logic        clk = 1'b0;
  logic        reset_n_i;
  logic [3:0]  req_i;
  logic [3:0]  grant_o;
  logic [15:0] data_o;
  logic        seed_v_i;
  logic [15:0] seed_i;
  logic        ready_o;
  logic [1:0]  state_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bsg_lfsr_sched dut (
    .clk       (clk),
    .reset_n_i (reset_n_i),
    .req_i     (req_i),
    .grant_o   (grant_o),
    .data_o    (data_o),
    .seed_v_i  (seed_v_i),
    .seed_i    (seed_i),
    .ready_o   (ready_o),
    .state_o   (state_o)
  );

  // Reference model: current value, who is next in line, mode
  // (0 warming, 1 serving, 2 seeding) and warm-up steps still owed.
  logic [15:0] m_lfsr;
  int          m_ptr, m_mode, m_left;

  function automatic logic [15:0] galois(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [3:0] m_grant();
    if (seed_v_i || m_mode != 1) return 4'b0;
    for (int k = 0; k < 4; k++)
      if (req_i[(m_ptr + k) % 4]) return 4'(1 << ((m_ptr + k) % 4));
    return 4'b0;
  endfunction

  task automatic model_reset();
    m_lfsr = 16'h0001; m_mode = 0; m_left = 4; m_ptr = 0;
  endtask

  // One clock: sample inputs before the edge, update model after it,
  // return at the following falling edge.
  task automatic tick();
    logic [3:0]  g;
    logic        sv;
    logic [15:0] sd;
    g = m_grant(); sv = seed_v_i; sd = seed_i;
    @(posedge clk);
    if (sv) begin
      m_lfsr = (sd == 16'h0) ? 16'h0001 : sd; m_mode = 2;
    end else if (m_mode == 2) begin
      m_mode = 0; m_left = 4;
    end else if (m_mode == 0) begin
      m_lfsr = galois(m_lfsr); m_left--;
      if (m_left == 0) m_mode = 1;
    end else if (g != 4'b0) begin
      m_lfsr = galois(m_lfsr);
      for (int i = 0; i < 4; i++) if (g[i]) m_ptr = (i + 1) % 4;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n_i = 1'b0; req_i = 4'b0; seed_v_i = 1'b0; seed_i = 16'h0;
    #12;
    n_cmp++; if (grant_o !== 4'b0) begin n_err++; $display("FAIL reset_grant: got %b want 0000", grant_o); end
    n_cmp++; if (ready_o !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0", ready_o); end
    n_cmp++; if (state_o !== 2'd0) begin n_err++; $display("FAIL reset_state: got %0d want 0", state_o); end
    n_cmp++; if (data_o !== 16'h0001) begin n_err++; $display("FAIL reset_lfsr: got %h want 0001", data_o); end
    @(negedge clk);
    reset_n_i = 1'b1;
    model_reset();
  endtask

  task automatic test_warmup();
    logic [15:0] ev [4];
    ev = '{16'hB400, 16'h5A00, 16'h2D00, 16'h1680};
    req_i = 4'b0;
    for (int i = 0; i < 4; i++) begin
      tick(); #1;
      n_cmp++; if (data_o !== ev[i]) begin n_err++; $display("FAIL warm_data[%0d]: got %h want %h", i, data_o, ev[i]); end
      n_cmp++; if (ready_o !== (i == 3)) begin n_err++; $display("FAIL warm_ready[%0d]: got %b want %b", i, ready_o, (i == 3)); end
      n_cmp++; if (grant_o !== 4'b0) begin n_err++; $display("FAIL warm_grant[%0d]: got %b want 0000", i, grant_o); end
    end
  endtask

  task automatic test_serve_rr();
    logic [3:0]  eg [6];
    logic [15:0] ed [6];
    eg = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    ed = '{16'h1680, 16'h0B40, 16'h05A0, 16'h02D0, 16'h0168, 16'h00B4};
    req_i = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      #1;
      n_cmp++; if (grant_o !== eg[i]) begin n_err++; $display("FAIL rr_grant[%0d]: got %b want %b", i, grant_o, eg[i]); end
      n_cmp++; if (data_o !== ed[i]) begin n_err++; $display("FAIL rr_data[%0d]: got %h want %h", i, data_o, ed[i]); end
      tick();
    end
  endtask

  // Pointer sits at 2 after the previous test.
  task automatic test_ptr_wrap();
    logic [3:0]  eg [3];
    logic [15:0] ed [3];
    eg = '{4'b0001, 4'b0010, 4'b0001};
    ed = '{16'h005A, 16'h002D, 16'hB416};
    req_i = 4'b0011;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (grant_o !== eg[i]) begin n_err++; $display("FAIL wrap_grant[%0d]: got %b want %b", i, grant_o, eg[i]); end
      n_cmp++; if (data_o !== ed[i]) begin n_err++; $display("FAIL wrap_data[%0d]: got %h want %h", i, data_o, ed[i]); end
      tick();
    end
    req_i = 4'b0;
    for (int i = 0; i < 2; i++) begin
      tick(); #1;
      n_cmp++; if (data_o !== 16'h5A0B) begin n_err++; $display("FAIL idle_hold[%0d]: got %h want 5a0b", i, data_o); end
      n_cmp++; if (grant_o !== 4'b0) begin n_err++; $display("FAIL idle_grant[%0d]: got %b want 0000", i, grant_o); end
    end
  endtask

  task automatic test_seed_collision();
    req_i = 4'b0001; seed_v_i = 1'b1; seed_i = 16'h0;
    #1;
    n_cmp++; if (grant_o !== 4'b0) begin n_err++; $display("FAIL coll_grant: got %b want 0000", grant_o); end
    tick();
    seed_v_i = 1'b0; #1;
    n_cmp++; if (state_o !== 2'd2) begin n_err++; $display("FAIL coll_state: got %0d want 2", state_o); end
    n_cmp++; if (data_o !== 16'h0001) begin n_err++; $display("FAIL coll_seed: got %h want 0001", data_o); end
    for (int i = 0; i < 5; i++) begin
      tick(); #1;
      n_cmp++; if (data_o !== m_lfsr) begin n_err++; $display("FAIL coll_warm[%0d]: got %h want %h", i, data_o, m_lfsr); end
    end
    n_cmp++; if (grant_o !== 4'b0001) begin n_err++; $display("FAIL coll_first_grant: got %b want 0001", grant_o); end
    n_cmp++; if (data_o !== 16'h1680) begin n_err++; $display("FAIL coll_first_data: got %h want 1680", data_o); end
    tick();
  endtask

  task automatic test_seed_midwarm();
    logic [15:0] ev [4];
    ev = '{16'hF400, 16'h7A00, 16'h3D00, 16'h1E80};
    req_i = 4'b0; seed_v_i = 1'b1; seed_i = 16'h1234;
    tick();
    seed_v_i = 1'b0;
    tick(); tick(); tick();
    seed_v_i = 1'b1; seed_i = 16'h8001;
    tick();
    seed_v_i = 1'b0; #1;
    n_cmp++; if (data_o !== 16'h8001) begin n_err++; $display("FAIL mid_seed: got %h want 8001", data_o); end
    tick();
    for (int i = 0; i < 4; i++) begin
      tick(); #1;
      n_cmp++; if (data_o !== ev[i]) begin n_err++; $display("FAIL mid_warm[%0d]: got %h want %h", i, data_o, ev[i]); end
      n_cmp++; if (ready_o !== (i == 3)) begin n_err++; $display("FAIL mid_ready[%0d]: got %b want %b", i, ready_o, (i == 3)); end
    end
    req_i = 4'b0100; #1;
    n_cmp++; if (grant_o !== 4'b0100) begin n_err++; $display("FAIL mid_grant: got %b want 0100", grant_o); end
    n_cmp++; if (data_o !== 16'h1E80) begin n_err++; $display("FAIL mid_data: got %h want 1e80", data_o); end
    tick();
  endtask

  task automatic test_reset_mid();
    logic [15:0] ev [4];
    ev = '{16'hB400, 16'h5A00, 16'h2D00, 16'h1680};
    req_i = 4'b1111;
    #2 reset_n_i = 1'b0;
    #1;
    n_cmp++; if (grant_o !== 4'b0) begin n_err++; $display("FAIL rmid_grant: got %b want 0000", grant_o); end
    n_cmp++; if (ready_o !== 1'b0) begin n_err++; $display("FAIL rmid_ready: got %b want 0", ready_o); end
    n_cmp++; if (data_o !== 16'h0001) begin n_err++; $display("FAIL rmid_lfsr: got %h want 0001", data_o); end
    #1 reset_n_i = 1'b1;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      tick(); #1;
      n_cmp++; if (data_o !== ev[i]) begin n_err++; $display("FAIL rmid_warm[%0d]: got %h want %h", i, data_o, ev[i]); end
    end
    n_cmp++; if (grant_o !== 4'b0001) begin n_err++; $display("FAIL rmid_first_grant: got %b want 0001", grant_o); end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      req_i    = 4'($urandom);
      seed_v_i = ($urandom_range(0, 19) == 0);
      seed_i   = ($urandom_range(0, 1) == 0) ? 16'h0 : 16'($urandom);
      #1;
      n_cmp++; if (grant_o !== m_grant()) begin n_err++; $display("FAIL rnd_grant[%0d]: got %b want %b", i, grant_o, m_grant()); end
      n_cmp++; if (data_o !== m_lfsr) begin n_err++; $display("FAIL rnd_data[%0d]: got %h want %h", i, data_o, m_lfsr); end
      n_cmp++; if (ready_o !== (m_mode == 1)) begin n_err++; $display("FAIL rnd_ready[%0d]: got %b want %b", i, ready_o, (m_mode == 1)); end
      n_cmp++; if (state_o !== 2'(m_mode)) begin n_err++; $display("FAIL rnd_state[%0d]: got %0d want %0d", i, state_o, m_mode); end
      tick();
    end
    seed_v_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_warmup();
    test_serve_rr();
    test_ptr_wrap();
    test_seed_collision();
    test_seed_midwarm();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
